// File: rtl/semaforo_pkg.sv
// Shared definitions for the traffic-light supervisor: FSM states, lamp
// encodings, default timing constants and small counter helpers.
package semaforo_pkg;

    localparam int DEF_DEBOUNCE_CYCLES  = 4;
    localparam int DEF_MIN_GREEN_CYCLES = 8;
    localparam int DEF_RED_CYCLES       = 16;
    localparam int CNT_W                = 16;

    typedef enum logic [2:0] {
        WAIT_GRN,
        GREEN_HOLD,
        ARMED,
        WAIT_RED,
        RED_COUNT,
        EXPIRED
    } state_t;

    // Controller lamp patterns as {GRN, YLW, RED}
    typedef enum logic [2:0] {
        LAMP_RED = 3'b001,
        LAMP_YLW = 3'b010,
        LAMP_GRN = 3'b100
    } lamp_t;

    function automatic logic lamps_onehot(input logic [2:0] lamps);
        case (lamps)
            LAMP_RED, LAMP_YLW, LAMP_GRN: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/semaforo_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for the
// vehicle-loop sensor.
module semaforo_debounce
    import semaforo_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dout  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            // Any matching sample restarts the run of differing samples
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= sat_inc(cnt);
            end
        end
    end

endmodule

// File: rtl/semaforo_timer.sv
// Supervises a traffic-light controller: issues a debounced vehicle request
// after minimum green, a red-phase timeout, and a sticky lamp-sequence fault.
module semaforo_timer
    import semaforo_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int MIN_GREEN_CYCLES = DEF_MIN_GREEN_CYCLES,
    parameter int RED_CYCLES       = DEF_RED_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic SENSOR,
    input  logic GRN,
    input  logic YLW,
    input  logic RED,
    output logic CAR,
    output logic TIMEOUT,
    output logic FAULT
);

    localparam logic [CNT_W-1:0] GRN_LAST = CNT_W'(MIN_GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] RED_LAST = CNT_W'(RED_CYCLES - 1);

    logic             sensor_db;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             car_nxt, timeout_nxt, fault_nxt;
    logic             lamp_bad, order_bad, fault_now;
    logic [1:0]       settle;

    semaforo_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk (clk),
        .rst (rst),
        .din (SENSOR),
        .dout(sensor_db)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= WAIT_GRN;
            cnt     <= '0;
            CAR     <= 1'b0;
            TIMEOUT <= 1'b0;
            FAULT   <= 1'b0;
            settle  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            CAR     <= car_nxt;
            TIMEOUT <= timeout_nxt;
            FAULT   <= fault_nxt;
            if (settle != 2'd2) settle <= settle + 2'd1;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        car_nxt     = 1'b0;
        timeout_nxt = 1'b0;
        order_bad   = 1'b0;
        // Controller lamps are unreliable for two cycles after our reset
        lamp_bad    = (settle == 2'd2) && !lamps_onehot({GRN, YLW, RED});

        case (state)
            WAIT_GRN: begin
                if (GRN) begin
                    state_nxt = GREEN_HOLD;
                    cnt_nxt   = '0;
                end
            end
            GREEN_HOLD: begin
                if (!GRN) begin
                    order_bad = 1'b1;
                end else if (cnt == GRN_LAST) begin
                    state_nxt = ARMED;
                    car_nxt   = sensor_db;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            ARMED: begin
                if (YLW) begin
                    state_nxt = WAIT_RED;
                end else if (!GRN) begin
                    order_bad = 1'b1;
                end else begin
                    car_nxt = sensor_db & GRN;
                end
            end
            WAIT_RED: begin
                if (RED) begin
                    state_nxt = RED_COUNT;
                    cnt_nxt   = '0;
                end
            end
            RED_COUNT: begin
                if (!RED) begin
                    order_bad = 1'b1;
                end else if (cnt == RED_LAST) begin
                    state_nxt   = EXPIRED;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            EXPIRED: begin
                if (GRN) begin
                    state_nxt = GREEN_HOLD;
                    cnt_nxt   = '0;
                end else begin
                    timeout_nxt = 1'b1;
                end
            end
            default: state_nxt = WAIT_GRN;
        endcase

        fault_now = lamp_bad | order_bad;
        if (fault_now) begin
            state_nxt   = WAIT_GRN;
            cnt_nxt     = '0;
            car_nxt     = 1'b0;
            timeout_nxt = 1'b0;
        end
        fault_nxt = FAULT | fault_now;
    end

endmodule

// File: tb/tb_semaforo_timer.sv
// Directed bench for semaforo_timer: default-parameter instance plus a
// minimum-parameter instance, each scenario in its own task.
module tb_semaforo_timer;

    logic clk = 1'b0;
    logic rst;
    logic sensor, grn, ylw, red;
    logic car, timeout, fault;
    logic sensor_m, grn_m, ylw_m, red_m;
    logic car_m, timeout_m, fault_m;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    semaforo_timer #(
        .DEBOUNCE_CYCLES (4),
        .MIN_GREEN_CYCLES(8),
        .RED_CYCLES      (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .SENSOR (sensor),
        .GRN    (grn),
        .YLW    (ylw),
        .RED    (red),
        .CAR    (car),
        .TIMEOUT(timeout),
        .FAULT  (fault)
    );

    semaforo_timer #(
        .DEBOUNCE_CYCLES (1),
        .MIN_GREEN_CYCLES(1),
        .RED_CYCLES      (1)
    ) dut_min (
        .clk    (clk),
        .rst    (rst),
        .SENSOR (sensor_m),
        .GRN    (grn_m),
        .YLW    (ylw_m),
        .RED    (red_m),
        .CAR    (car_m),
        .TIMEOUT(timeout_m),
        .FAULT  (fault_m)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lamps(input logic g, input logic y, input logic r);
        grn = g;
        ylw = y;
        red = r;
    endtask

    task automatic reset_dut(input logic g, input logic y, input logic r, input logic s);
        rst = 1'b1;
        set_lamps(g, y, r);
        sensor = s;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_lamps(1'b1, 1'b1, 1'b1);
        sensor = 1'b1;
        repeat (3) step();
        vectors++;
        if ({car, timeout, fault} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_outputs: {CAR,TIMEOUT,FAULT}=%b expected 000", {car, timeout, fault});
        end
    endtask

    task automatic test_exempt();
        reset_dut(1'b1, 1'b1, 1'b1, 1'b0);
        step();
        step();
        vectors++;
        if (fault !== 1'b0) begin
            miscompares++;
            $display("FAIL exempt_two_cycles: FAULT=%b expected 0", fault);
        end
        step();
        vectors++;
        if (fault !== 1'b1) begin
            miscompares++;
            $display("FAIL exempt_third_cycle: FAULT=%b expected 1", fault);
        end
        reset_dut(1'b1, 1'b1, 1'b1, 1'b0);
        step();
        step();
        set_lamps(1'b1, 1'b0, 1'b0);
        repeat (5) step();
        vectors++;
        if (fault !== 1'b0) begin
            miscompares++;
            $display("FAIL exempt_then_clean: FAULT=%b expected 0", fault);
        end
    endtask

    task automatic test_glitch();
        reset_dut(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            sensor = ((i % 5) < 2);
            step();
            vectors++;
            if (car !== 1'b0) begin
                miscompares++;
                $display("FAIL glitch_car[%0d]: CAR=%b expected 0", i, car);
            end
        end
    endtask

    task automatic test_car_timing();
        logic exp;
        reset_dut(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            step();
            exp = (i == 9);
            vectors++;
            if (car !== exp) begin
                miscompares++;
                $display("FAIL car_rise[%0d]: CAR=%b expected %b", i, car, exp);
            end
        end
        repeat (3) step();
        vectors++;
        if (car !== 1'b1) begin
            miscompares++;
            $display("FAIL car_hold: CAR=%b expected 1", car);
        end
        set_lamps(1'b0, 1'b1, 1'b0);
        step();
        vectors++;
        if ({car, fault} !== 2'b00) begin
            miscompares++;
            $display("FAIL car_fall_on_yellow: {CAR,FAULT}=%b expected 00", {car, fault});
        end
    endtask

    task automatic test_full_cycle();
        logic exp;
        reset_dut(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) step();
        set_lamps(1'b0, 1'b1, 1'b0);
        repeat (3) step();
        set_lamps(1'b0, 1'b0, 1'b1);
        step();
        vectors++;
        if (timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL red_first_sample: TIMEOUT=%b expected 0", timeout);
        end
        for (int i = 1; i <= 16; i++) begin
            step();
            exp = (i == 16);
            vectors++;
            if (timeout !== exp) begin
                miscompares++;
                $display("FAIL timeout_rise[%0d]: TIMEOUT=%b expected %b", i, timeout, exp);
            end
        end
        repeat (3) step();
        vectors++;
        if ({timeout, fault} !== 2'b10) begin
            miscompares++;
            $display("FAIL timeout_hold: {TIMEOUT,FAULT}=%b expected 10", {timeout, fault});
        end
        set_lamps(1'b1, 1'b0, 1'b0);
        step();
        vectors++;
        if ({timeout, fault} !== 2'b00) begin
            miscompares++;
            $display("FAIL timeout_fall_on_green: {TIMEOUT,FAULT}=%b expected 00", {timeout, fault});
        end
    endtask

    task automatic test_lamp_fault();
        reset_dut(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (9) step();
        vectors++;
        if (car !== 1'b1) begin
            miscompares++;
            $display("FAIL fault_precondition_car: CAR=%b expected 1", car);
        end
        set_lamps(1'b1, 1'b0, 1'b1);
        step();
        vectors++;
        if ({fault, car, timeout} !== 3'b100) begin
            miscompares++;
            $display("FAIL onehot_fault: {FAULT,CAR,TIMEOUT}=%b expected 100", {fault, car, timeout});
        end
        set_lamps(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++;
            if (fault !== 1'b1) begin
                miscompares++;
                $display("FAIL fault_sticky[%0d]: FAULT=%b expected 1", i, fault);
            end
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (fault !== 1'b0) begin
            miscompares++;
            $display("FAIL fault_cleared_by_rst: FAULT=%b expected 0", fault);
        end
    endtask

    task automatic test_order_faults();
        reset_dut(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        set_lamps(1'b0, 1'b1, 1'b0);
        step();
        vectors++;
        if (fault !== 1'b1) begin
            miscompares++;
            $display("FAIL grn_drop_green_hold: FAULT=%b expected 1", fault);
        end

        reset_dut(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (10) step();
        set_lamps(1'b0, 1'b0, 1'b1);
        step();
        vectors++;
        if ({fault, car} !== 2'b10) begin
            miscompares++;
            $display("FAIL grn_drop_armed: {FAULT,CAR}=%b expected 10", {fault, car});
        end

        reset_dut(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) step();
        set_lamps(1'b0, 1'b1, 1'b0);
        step();
        set_lamps(1'b0, 1'b0, 1'b1);
        repeat (5) step();
        set_lamps(1'b1, 1'b0, 1'b0);
        step();
        vectors++;
        if ({fault, timeout} !== 2'b10) begin
            miscompares++;
            $display("FAIL red_drop_red_count: {FAULT,TIMEOUT}=%b expected 10", {fault, timeout});
        end
    endtask

    task automatic test_reset_midred();
        reset_dut(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) step();
        set_lamps(1'b0, 1'b1, 1'b0);
        step();
        set_lamps(1'b0, 1'b0, 1'b1);
        step();
        repeat (7) step();
        rst = 1'b1;
        #1;
        vectors++;
        if ({car, timeout, fault} !== 3'b000) begin
            miscompares++;
            $display("FAIL midred_rst_outputs: {CAR,TIMEOUT,FAULT}=%b expected 000", {car, timeout, fault});
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            vectors++;
            if ({timeout, fault} !== 2'b00) begin
                miscompares++;
                $display("FAIL midred_wait[%0d]: {TIMEOUT,FAULT}=%b expected 00", i, {timeout, fault});
            end
        end
        set_lamps(1'b1, 1'b0, 1'b0);
        step();
        vectors++;
        if ({car, timeout, fault} !== 3'b000) begin
            miscompares++;
            $display("FAIL midred_green_return: {CAR,TIMEOUT,FAULT}=%b expected 000", {car, timeout, fault});
        end
        repeat (9) step();
        set_lamps(1'b0, 1'b1, 1'b0);
        step();
        set_lamps(1'b0, 1'b0, 1'b1);
        repeat (17) step();
        vectors++;
        if (timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL expired_reached: TIMEOUT=%b expected 1", timeout);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL expired_async_rst: TIMEOUT=%b expected 0", timeout);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_min_params();
        logic exp;
        rst = 1'b1;
        grn_m = 1'b1;
        ylw_m = 1'b0;
        red_m = 1'b0;
        sensor_m = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        vectors++;
        if (car_m !== 1'b0) begin
            miscompares++;
            $display("FAIL min_armed_no_sensor: CAR=%b expected 0", car_m);
        end
        sensor_m = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            exp = (i == 4);
            vectors++;
            if (car_m !== exp) begin
                miscompares++;
                $display("FAIL min_car_rise[%0d]: CAR=%b expected %b", i, car_m, exp);
            end
        end
        grn_m = 1'b0;
        ylw_m = 1'b1;
        step();
        vectors++;
        if (car_m !== 1'b0) begin
            miscompares++;
            $display("FAIL min_car_fall: CAR=%b expected 0", car_m);
        end
        ylw_m = 1'b0;
        red_m = 1'b1;
        step();
        vectors++;
        if (timeout_m !== 1'b0) begin
            miscompares++;
            $display("FAIL min_red_first_sample: TIMEOUT=%b expected 0", timeout_m);
        end
        step();
        vectors++;
        if (timeout_m !== 1'b1) begin
            miscompares++;
            $display("FAIL min_timeout_rise: TIMEOUT=%b expected 1", timeout_m);
        end
        red_m = 1'b0;
        grn_m = 1'b1;
        step();
        vectors++;
        if ({timeout_m, fault_m} !== 2'b00) begin
            miscompares++;
            $display("FAIL min_timeout_fall: {TIMEOUT,FAULT}=%b expected 00", {timeout_m, fault_m});
        end
    endtask

    initial begin
        rst = 1'b1;
        sensor = 1'b0;
        grn = 1'b0;
        ylw = 1'b0;
        red = 1'b0;
        sensor_m = 1'b0;
        grn_m = 1'b0;
        ylw_m = 1'b0;
        red_m = 1'b0;

        test_reset();
        test_exempt();
        test_glitch();
        test_car_timing();
        test_full_cycle();
        test_lamp_fault();
        test_order_faults();
        test_reset_midred();
        test_min_params();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
